// File: rtl/axi_lite_pkg.sv
// ---------------------------------------------------------------------------
// axi_lite_pkg
// Shared AXI4-Lite definitions for the initiator and the register slaves.
//   - Default address/data widths.
//   - BRESP/RRESP response codes.
//   - State encoding of the axi_lite_initiator FSM. The state is also
//     brought out on the initiator's dbg_state_o port.
// ---------------------------------------------------------------------------
package axi_lite_pkg;

    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 32;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_RESP = 3'd4,
        ST_RSP     = 3'd5
    } init_state_e;

endpackage

// File: rtl/axi_lite_initiator_if.sv
// ---------------------------------------------------------------------------
// axi_lite_initiator_if
// AXI4-Lite bus between one initiator and one slave. It carries the five
// channels AW, W, B, AR and R.
//   master modport : drives AW/W/AR payload and VALIDs, and BREADY/RREADY
//   slave  modport : drives AWREADY/WREADY/ARREADY, and the B/R payload and
//                    VALIDs
//
// Handshake rule on every channel:
//   A transfer happens on a rising ACLK edge where VALID and READY are both
//   high. Once VALID is raised it stays high, and its payload stays stable,
//   until that edge. READY may be raised or lowered freely.
// ---------------------------------------------------------------------------
interface axi_lite_initiator_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   AWADDR;
    logic                AWVALID;
    logic                AWREADY;
    logic [DATA_W-1:0]   WDATA;
    logic [DATA_W/8-1:0] WSTRB;
    logic                WVALID;
    logic                WREADY;
    logic [1:0]          BRESP;
    logic                BVALID;
    logic                BREADY;
    logic [ADDR_W-1:0]   ARADDR;
    logic                ARVALID;
    logic                ARREADY;
    logic [DATA_W-1:0]   RDATA;
    logic [1:0]          RRESP;
    logic                RVALID;
    logic                RREADY;

    modport master (
        output AWADDR, AWVALID, input AWREADY,
        output WDATA, WSTRB, WVALID, input WREADY,
        input  BRESP, BVALID, output BREADY,
        output ARADDR, ARVALID, input ARREADY,
        input  RDATA, RRESP, RVALID, output RREADY
    );

    modport slave (
        input  AWADDR, AWVALID, output AWREADY,
        input  WDATA, WSTRB, WVALID, output WREADY,
        output BRESP, BVALID, input BREADY,
        input  ARADDR, ARVALID, output ARREADY,
        output RDATA, RRESP, RVALID, input RREADY
    );
endinterface

// File: rtl/axi_lite_watchdog.sv
// ---------------------------------------------------------------------------
// axi_lite_watchdog
// Saturating counter of outstanding cycles, with a sticky timeout flag.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   start_i       : clears the counter (command handshake)
//   run_i         : count this cycle (a transaction is outstanding)
//   clr_i         : clears err_o; loses to a timeout event in the same cycle
//   err_o         : sticky flag. It rises after TIMEOUT counted cycles.
// ---------------------------------------------------------------------------
module axi_lite_watchdog #(
    parameter int TIMEOUT = 256
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic start_i,
    input  logic run_i,
    input  logic clr_i,
    output logic err_o
);
    localparam int              CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SAT  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic             err_q;
    logic             fire;

    // The event fires on the increment that takes the count to TIMEOUT.
    // After that the counter parks at SAT, so the event happens only once
    // per transaction.
    assign fire = run_i && !start_i && (cnt_q == LAST);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (start_i) begin
                cnt_q <= '0;
            end else if (run_i && (cnt_q != SAT)) begin
                cnt_q <= cnt_q + ONE;
            end

            if (fire) begin
                err_q <= 1'b1;
            end else if (clr_i) begin
                err_q <= 1'b0;
            end
        end
    end

    assign err_o = err_q;

endmodule

// File: rtl/axi_lite_initiator.sv
// ---------------------------------------------------------------------------
// axi_lite_initiator
// AXI4-Lite master. It turns single-beat commands into AXI4-Lite read or
// write transactions, with one transaction outstanding at a time.
//   ACLK, ARESETN  : clock, asynchronous active-low reset
//   cmd_*          : command port (valid/ready). cmd_ready is high only
//                    in IDLE.
//   rsp_*          : response port. Held stable from rsp_valid until
//                    rsp_ready.
//   timeout_err    : sticky watchdog flag; timeout_clr clears it
//   dbg_state_o    : current FSM state
//   axi            : AXI4-Lite master side. All outputs come from flops.
// ---------------------------------------------------------------------------
module axi_lite_initiator
    import axi_lite_pkg::*;
#(
    parameter int ADDR_W  = AXI_ADDR_W,
    parameter int DATA_W  = AXI_DATA_W,   // 32 or 64
    parameter int TIMEOUT = 256           // >= 2
) (
    input  logic                ACLK,
    input  logic                ARESETN,

    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_wstrb,

    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_write,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic [1:0]          rsp_resp,

    output logic                timeout_err,
    input  logic                timeout_clr,

    output init_state_e         dbg_state_o,

    axi_lite_initiator_if.master axi
);
    localparam int STRB_W = DATA_W / 8;

    init_state_e       state_q;
    logic              cmd_ready_q;
    logic [ADDR_W-1:0] awaddr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0] wstrb_q;
    logic              awvalid_q;
    logic              wvalid_q;
    logic              bready_q;
    logic [ADDR_W-1:0] araddr_q;
    logic              arvalid_q;
    logic              rready_q;
    logic              aw_done_q;
    logic              w_done_q;
    logic              rsp_valid_q;
    logic              rsp_write_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic [1:0]        rsp_resp_q;

    logic cmd_hs, rsp_hs, aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic aw_done_d, w_done_d;
    logic outstanding;

    // Each handshake is qualified by our own registered VALID/READY. This
    // is why a B/R beat arriving outside its state has no effect.
    assign cmd_hs = cmd_ready_q & cmd_valid;
    assign rsp_hs = rsp_valid_q & rsp_ready;
    assign aw_hs  = awvalid_q   & axi.AWREADY;
    assign w_hs   = wvalid_q    & axi.WREADY;
    assign b_hs   = bready_q    & axi.BVALID;
    assign ar_hs  = arvalid_q   & axi.ARREADY;
    assign r_hs   = rready_q    & axi.RVALID;

    // AW and W can complete in any order. A channel counts as done if it
    // finished earlier or is finishing this cycle.
    assign aw_done_d = aw_done_q | aw_hs;
    assign w_done_d  = w_done_q  | w_hs;

    assign outstanding = (state_q == ST_WR_REQ)  || (state_q == ST_WR_RESP) ||
                         (state_q == ST_RD_REQ)  || (state_q == ST_RD_RESP);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b1;
            awaddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            araddr_q    <= '0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= RESP_OKAY;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_hs) begin
                        cmd_ready_q <= 1'b0;
                        if (cmd_write) begin
                            awaddr_q  <= cmd_addr;
                            wdata_q   <= cmd_wdata;
                            wstrb_q   <= cmd_wstrb;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            aw_done_q <= 1'b0;
                            w_done_q  <= 1'b0;
                            state_q   <= ST_WR_REQ;
                        end else begin
                            araddr_q  <= cmd_addr;
                            arvalid_q <= 1'b1;
                            state_q   <= ST_RD_REQ;
                        end
                    end
                end

                ST_WR_REQ: begin
                    if (aw_hs) awvalid_q <= 1'b0;
                    if (w_hs)  wvalid_q  <= 1'b0;
                    aw_done_q <= aw_done_d;
                    w_done_q  <= w_done_d;
                    if (aw_done_d && w_done_d) begin
                        bready_q <= 1'b1;
                        state_q  <= ST_WR_RESP;
                    end
                end

                ST_WR_RESP: begin
                    if (b_hs) begin
                        bready_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_write_q <= 1'b1;
                        rsp_rdata_q <= '0;
                        rsp_resp_q  <= axi.BRESP;
                        state_q     <= ST_RSP;
                    end
                end

                ST_RD_REQ: begin
                    if (ar_hs) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= ST_RD_RESP;
                    end
                end

                ST_RD_RESP: begin
                    if (r_hs) begin
                        rready_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_write_q <= 1'b0;
                        rsp_rdata_q <= axi.RDATA;
                        rsp_resp_q  <= axi.RRESP;
                        state_q     <= ST_RSP;
                    end
                end

                ST_RSP: begin
                    if (rsp_hs) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end

                default: begin
                    state_q     <= ST_IDLE;
                    cmd_ready_q <= 1'b1;
                end
            endcase
        end
    end

    // The watchdog only raises a flag. It never aborts the transaction, so
    // every VALID stays up until its handshake.
    axi_lite_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk_i   (ACLK),
        .rst_ni  (ARESETN),
        .start_i (cmd_hs),
        .run_i   (outstanding),
        .clr_i   (timeout_clr),
        .err_o   (timeout_err)
    );

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_write   = rsp_write_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_resp    = rsp_resp_q;
    assign dbg_state_o = state_q;

    assign axi.AWADDR  = awaddr_q;
    assign axi.AWVALID = awvalid_q;
    assign axi.WDATA   = wdata_q;
    assign axi.WSTRB   = wstrb_q;
    assign axi.WVALID  = wvalid_q;
    assign axi.BREADY  = bready_q;
    assign axi.ARADDR  = araddr_q;
    assign axi.ARVALID = arvalid_q;
    assign axi.RREADY  = rready_q;

endmodule

// File: tb/tb_axi_lite_initiator.sv
module tb_axi_lite_initiator;
  import axi_lite_pkg::*;

  // ---------------- clock / reset ----------------
  logic        ACLK;
  logic        ARESETN;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        timeout_err;
  logic        timeout_clr;
  init_state_e dbg_state;

  int errors = 0;
  int checks = 0;

  axi_lite_initiator_if #(.ADDR_W(32), .DATA_W(32)) axi ();

  axi_lite_initiator #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (8)
  ) dut (
    .ACLK        (ACLK),
    .ARESETN     (ARESETN),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .cmd_wstrb   (cmd_wstrb),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_write   (rsp_write),
    .rsp_rdata   (rsp_rdata),
    .rsp_resp    (rsp_resp),
    .timeout_err (timeout_err),
    .timeout_clr (timeout_clr),
    .dbg_state_o (dbg_state),
    .axi         (axi)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  initial begin
    #200000;
    $display("FAIL sim_timeout: got running want finished");
    $fatal(1);
  end

  // one cycle forward; outputs are sampled 1 ns after the rising edge
  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic issue_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = data;
    cmd_wstrb = strb;
  endtask

  // ---------------- driver tasks / scenarios ----------------
  task automatic test_reset();
    ARESETN = 1'b0;
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 0; timeout_clr = 0;
    axi.AWREADY = 0; axi.WREADY = 0; axi.BVALID = 0; axi.BRESP = 2'b00;
    axi.ARREADY = 0; axi.RVALID = 0; axi.RDATA = '0; axi.RRESP = 2'b00;
    step(); step();
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_cmd_ready: got %b want 1", cmd_ready); end
    checks++; if ({axi.AWVALID, axi.WVALID, axi.BREADY, axi.ARVALID, axi.RREADY} !== 5'b0) begin errors++; $display("FAIL rst_axi_handshake: got %b want 00000", {axi.AWVALID, axi.WVALID, axi.BREADY, axi.ARVALID, axi.RREADY}); end
    checks++; if ({axi.AWADDR, axi.WDATA, axi.WSTRB, axi.ARADDR} !== 100'b0) begin errors++; $display("FAIL rst_axi_payload: got %h want 0", {axi.AWADDR, axi.WDATA, axi.WSTRB, axi.ARADDR}); end
    checks++; if ({rsp_valid, rsp_write, rsp_rdata, rsp_resp, timeout_err} !== 37'b0) begin errors++; $display("FAIL rst_rsp: got %h want 0", {rsp_valid, rsp_write, rsp_rdata, rsp_resp, timeout_err}); end
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL rst_state: got %0d want %0d", dbg_state, ST_IDLE); end
    ARESETN = 1'b1;
    step();
    // stray B/R beats in IDLE must have no effect
    axi.BVALID = 1; axi.RVALID = 1; axi.RDATA = 32'h1111_2222;
    step();
    checks++; if (rsp_valid !== 1'b0 || dbg_state !== ST_IDLE) begin errors++; $display("FAIL stray_br: got rsp_valid=%b state=%0d want 0/%0d", rsp_valid, dbg_state, ST_IDLE); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL stray_cmd_ready: got %b want 1", cmd_ready); end
    axi.BVALID = 0; axi.RVALID = 0;
  endtask

  task automatic test_write();
    axi.AWREADY = 1; axi.WREADY = 1;
    issue_cmd(1'b1, 32'h0000_4140, 32'h1A2B_3C4D, 4'hF);                  // cycle 0
    step(); cmd_valid = 0;                                                  // cycle 1
    checks++; if (axi.AWVALID !== 1'b1 || axi.WVALID !== 1'b1) begin errors++; $display("FAIL wr_valid_c1: got aw=%b w=%b want 1/1", axi.AWVALID, axi.WVALID); end
    checks++; if (axi.AWADDR !== 32'h0000_4140 || axi.WDATA !== 32'h1A2B_3C4D || axi.WSTRB !== 4'hF) begin errors++; $display("FAIL wr_payload: got %h %h %h want 00004140 1a2b3c4d f", axi.AWADDR, axi.WDATA, axi.WSTRB); end
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL wr_cmd_ready_busy: got %b want 0", cmd_ready); end
    step();                                                                  // cycle 2
    checks++; if ({axi.AWVALID, axi.WVALID, axi.BREADY} !== 3'b001) begin errors++; $display("FAIL wr_c2: got aw/w/b=%b want 001", {axi.AWVALID, axi.WVALID, axi.BREADY}); end
    axi.BVALID = 1; axi.BRESP = 2'b00;
    step(); axi.BVALID = 0;                                                  // cycle 3
    checks++; if (rsp_valid !== 1'b1 || rsp_write !== 1'b1 || rsp_resp !== 2'b00 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL wr_rsp: got v=%b w=%b resp=%b rdata=%h want 1 1 00 0", rsp_valid, rsp_write, rsp_resp, rsp_rdata); end
    checks++; if (axi.BREADY !== 1'b0) begin errors++; $display("FAIL wr_bready_drop: got %b want 0", axi.BREADY); end
    rsp_ready = 1;
    step(); rsp_ready = 0;                                                   // cycle 4
    checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL wr_done: got rsp_valid=%b cmd_ready=%b want 0/1", rsp_valid, cmd_ready); end
  endtask

  task automatic test_skewed_write();
    axi.AWREADY = 0; axi.WREADY = 1;
    issue_cmd(1'b1, 32'h0000_0A04, 32'h0F0E_0D0C, 4'h6);                    // cycle 0
    step(); cmd_valid = 0;                                                   // cycle 1: W handshake
    checks++; if (axi.AWVALID !== 1'b1 || axi.WVALID !== 1'b1) begin errors++; $display("FAIL skw_c1: got aw=%b w=%b want 1/1", axi.AWVALID, axi.WVALID); end
    for (int c = 2; c <= 4; c++) begin
      step();
      if (c == 4) axi.AWREADY = 1;
      checks++; if (axi.WVALID !== 1'b0 || axi.AWVALID !== 1'b1 || axi.BREADY !== 1'b0) begin errors++; $display("FAIL skw_hold_c%0d: got aw/w/b=%b want 100", c, {axi.AWVALID, axi.WVALID, axi.BREADY}); end
      checks++; if (axi.AWADDR !== 32'h0000_0A04) begin errors++; $display("FAIL skw_awaddr_c%0d: got %h want 00000a04", c, axi.AWADDR); end
    end
    step(); axi.AWREADY = 0;                                                 // cycle 5
    checks++; if ({axi.AWVALID, axi.WVALID, axi.BREADY} !== 3'b001) begin errors++; $display("FAIL skw_c5: got aw/w/b=%b want 001", {axi.AWVALID, axi.WVALID, axi.BREADY}); end
    axi.BVALID = 1; axi.BRESP = 2'b11;
    step(); axi.BVALID = 0;                                                  // cycle 6
    checks++; if (rsp_valid !== 1'b1 || rsp_resp !== 2'b11 || rsp_write !== 1'b1) begin errors++; $display("FAIL skw_rsp: got v=%b resp=%b w=%b want 1 11 1", rsp_valid, rsp_resp, rsp_write); end
    rsp_ready = 1;
    step(); rsp_ready = 0;
  endtask

  task automatic test_read();
    axi.ARREADY = 1;
    issue_cmd(1'b0, 32'h0000_0010, 32'h0, 4'h0);                            // cycle 0
    step(); cmd_valid = 0;                                                   // cycle 1
    checks++; if (axi.ARVALID !== 1'b1 || axi.ARADDR !== 32'h0000_0010 || axi.AWVALID !== 1'b0) begin errors++; $display("FAIL rd_c1: got arv=%b araddr=%h awv=%b want 1 00000010 0", axi.ARVALID, axi.ARADDR, axi.AWVALID); end
    step(); axi.ARREADY = 0;                                                 // cycle 2
    checks++; if (axi.ARVALID !== 1'b0 || axi.RREADY !== 1'b1) begin errors++; $display("FAIL rd_c2: got arv=%b rready=%b want 0/1", axi.ARVALID, axi.RREADY); end
    step();                                                                  // cycle 3 (wait)
    step();                                                                  // cycle 4
    checks++; if (rsp_valid !== 1'b0 || axi.RREADY !== 1'b1) begin errors++; $display("FAIL rd_wait: got rsp_valid=%b rready=%b want 0/1", rsp_valid, axi.RREADY); end
    axi.RVALID = 1; axi.RDATA = 32'hDEAD_BEEF; axi.RRESP = 2'b10;
    step(); axi.RVALID = 0;                                                  // cycle 5
    checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEAD_BEEF || rsp_resp !== 2'b10 || rsp_write !== 1'b0) begin errors++; $display("FAIL rd_rsp: got v=%b rdata=%h resp=%b w=%b want 1 deadbeef 10 0", rsp_valid, rsp_rdata, rsp_resp, rsp_write); end
    checks++; if (axi.RREADY !== 1'b0) begin errors++; $display("FAIL rd_rready_drop: got %b want 0", axi.RREADY); end
    rsp_ready = 1;
    step(); rsp_ready = 0;
  endtask

  task automatic test_backpressure();
    axi.ARREADY = 1; axi.AWREADY = 1; axi.WREADY = 1;
    issue_cmd(1'b0, 32'h0000_0020, 32'h0, 4'h0);                            // cycle 0
    step(); cmd_valid = 0;                                                   // cycle 1
    step(); axi.ARREADY = 0;                                                 // cycle 2
    axi.RVALID = 1; axi.RDATA = 32'h0BAD_F00D; axi.RRESP = 2'b00;
    step(); axi.RVALID = 0;                                                  // cycle 3
    issue_cmd(1'b1, 32'h0000_0030, 32'h55AA_55AA, 4'h3);
    for (int c = 3; c <= 7; c++) begin
      checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0BAD_F00D || rsp_resp !== 2'b00 || rsp_write !== 1'b0) begin errors++; $display("FAIL bp_hold_c%0d: got v=%b rdata=%h resp=%b w=%b want 1 0badf00d 00 0", c, rsp_valid, rsp_rdata, rsp_resp, rsp_write); end
      checks++; if (cmd_ready !== 1'b0 || axi.AWVALID !== 1'b0) begin errors++; $display("FAIL bp_busy_c%0d: got cmd_ready=%b awv=%b want 0/0", c, cmd_ready, axi.AWVALID); end
      step();
    end
    rsp_ready = 1;                                                           // cycle 8: rsp handshake
    step(); rsp_ready = 0;                                                   // cycle 9
    checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || axi.AWVALID !== 1'b0) begin errors++; $display("FAIL bp_c9: got rsp_valid=%b cmd_ready=%b awv=%b want 0 1 0", rsp_valid, cmd_ready, axi.AWVALID); end
    step(); cmd_valid = 0;                                                   // cycle 10
    checks++; if (axi.AWVALID !== 1'b1 || axi.AWADDR !== 32'h0000_0030 || axi.WSTRB !== 4'h3 || cmd_ready !== 1'b0) begin errors++; $display("FAIL bp_next_cmd: got awv=%b awaddr=%h wstrb=%h cmd_ready=%b want 1 00000030 3 0", axi.AWVALID, axi.AWADDR, axi.WSTRB, cmd_ready); end
    step();                                                                  // cycle 11
    axi.BVALID = 1; axi.BRESP = 2'b10;
    step(); axi.BVALID = 0;                                                  // cycle 12
    checks++; if (rsp_valid !== 1'b1 || rsp_resp !== 2'b10 || rsp_write !== 1'b1 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL bp_wr_rsp: got v=%b resp=%b w=%b rdata=%h want 1 10 1 0", rsp_valid, rsp_resp, rsp_write, rsp_rdata); end
    rsp_ready = 1;
    step(); rsp_ready = 0;
    axi.AWREADY = 0; axi.WREADY = 0;
  endtask

  task automatic finish_read(input logic [31:0] data, input logic [1:0] resp, input string tag);
    axi.ARREADY = 1;
    step(); axi.ARREADY = 0;
    checks++; if (axi.ARVALID !== 1'b0 || axi.RREADY !== 1'b1) begin errors++; $display("FAIL %s_late_ar: got arv=%b rready=%b want 0/1", tag, axi.ARVALID, axi.RREADY); end
    axi.RVALID = 1; axi.RDATA = data; axi.RRESP = resp;
    step(); axi.RVALID = 0;
    checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== data || rsp_resp !== resp) begin errors++; $display("FAIL %s_rsp: got v=%b rdata=%h resp=%b want 1 %h %b", tag, rsp_valid, rsp_rdata, rsp_resp, data, resp); end
    rsp_ready = 1;
    step(); rsp_ready = 0;
  endtask

  task automatic test_timeout();
    axi.ARREADY = 0;
    issue_cmd(1'b0, 32'h0000_0040, 32'h0, 4'h0);                            // cycle 0
    step(); cmd_valid = 0;                                                   // cycle 1
    for (int c = 1; c <= 8; c++) begin
      if (c > 1) step();
      checks++; if (timeout_err !== 1'b0 || axi.ARVALID !== 1'b1) begin errors++; $display("FAIL to_pre_c%0d: got err=%b arv=%b want 0/1", c, timeout_err, axi.ARVALID); end
    end
    step();                                                                  // cycle 9
    checks++; if (timeout_err !== 1'b1 || axi.ARVALID !== 1'b1 || axi.ARADDR !== 32'h0000_0040) begin errors++; $display("FAIL to_set: got err=%b arv=%b araddr=%h want 1 1 00000040", timeout_err, axi.ARVALID, axi.ARADDR); end
    timeout_clr = 1;
    step(); timeout_clr = 0;                                                 // cycle 10
    checks++; if (timeout_err !== 1'b0 || axi.ARVALID !== 1'b1) begin errors++; $display("FAIL to_clr: got err=%b arv=%b want 0/1", timeout_err, axi.ARVALID); end
    finish_read(32'h0000_0777, 2'b01, "to");
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_no_refire: got %b want 0", timeout_err); end

    // clear held through the timeout event: set must win
    timeout_clr = 1;
    issue_cmd(1'b0, 32'h0000_0044, 32'h0, 4'h0);                            // cycle 0
    step(); cmd_valid = 0;
    for (int c = 2; c <= 9; c++) step();                                     // cycle 9
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_set_wins: got %b want 1", timeout_err); end
    step(); timeout_clr = 0;                                                 // cycle 10
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_clr2: got %b want 0", timeout_err); end
    finish_read(32'hA5A5_0001, 2'b00, "to2");
  endtask

  task automatic test_reset_mid_write();
    axi.AWREADY = 0; axi.WREADY = 0;
    issue_cmd(1'b1, 32'h0000_0050, 32'hCAFE_F00D, 4'hF);                    // cycle 0
    step(); cmd_valid = 0;                                                   // cycle 1
    checks++; if (axi.AWVALID !== 1'b1 || axi.WVALID !== 1'b1) begin errors++; $display("FAIL mrst_pre: got aw=%b w=%b want 1/1", axi.AWVALID, axi.WVALID); end
    #2 ARESETN = 0;
    #1;
    checks++; if ({axi.AWVALID, axi.WVALID, axi.BREADY, axi.ARVALID, axi.RREADY} !== 5'b0) begin errors++; $display("FAIL mrst_valids: got %b want 00000", {axi.AWVALID, axi.WVALID, axi.BREADY, axi.ARVALID, axi.RREADY}); end
    checks++; if (axi.AWADDR !== 32'h0 || axi.WDATA !== 32'h0 || axi.WSTRB !== 4'h0) begin errors++; $display("FAIL mrst_payload: got %h %h %h want 0 0 0", axi.AWADDR, axi.WDATA, axi.WSTRB); end
    checks++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || dbg_state !== ST_IDLE) begin errors++; $display("FAIL mrst_ctrl: got cmd_ready=%b rsp_valid=%b state=%0d want 1 0 %0d", cmd_ready, rsp_valid, dbg_state, ST_IDLE); end
    #1 ARESETN = 1;
    step();
    checks++; if (cmd_ready !== 1'b1 || axi.AWVALID !== 1'b0) begin errors++; $display("FAIL mrst_after: got cmd_ready=%b awv=%b want 1/0", cmd_ready, axi.AWVALID); end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_write();
    test_skewed_write();
    test_read();
    test_backpressure();
    test_timeout();
    test_reset_mid_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
